// File: rtl/clock_mode_ctrl.sv
// Button front-end for the clock display: sync/debounce, 1 ms tick, mode arbitration, display mux.
// Optional auto-repeat of bC/bD is compiled in with CLOCK_MODE_CTRL_AUTOREPEAT_EN.

module clock_mode_ctrl_db #(
  parameter int DB_TICKS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic stable
);
  localparam int DW = $clog2(DB_TICKS + 1);

  logic          s1, s2;
  logic [DW-1:0] cnt;

  // Count ticks only while the synced level disagrees; any agreement restarts the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == DW'(DB_TICKS - 1)) begin
          stable <= s2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

module clock_mode_ctrl #(
  parameter int CLK_DIV   = 100000,
  parameter int DB_TICKS  = 10,
  parameter int REP_DELAY = 500,
  parameter int REP_RATE  = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  btn_raw,
  input  logic [2:0]  edit_in,
  input  logic [35:0] time_clk,
  input  logic [35:0] time_tmr,
  input  logic [35:0] time_sw,
  output logic        tick,
  output logic [1:0]  mode,
  output logic [3:0]  btn_clk,
  output logic [3:0]  btn_tmr,
  output logic [3:0]  btn_sw,
  output logic [35:0] disp_time,
  output logic        disp_edit
);
  localparam int NUM_BTN = 5;
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {M_CLK = 2'd0, M_TMR = 2'd1, M_SW = 2'd2} mode_t;

  logic [PW-1:0]      pcnt;
  logic [NUM_BTN-1:0] stable, stable_q, press;
  logic [3:0]         rep_pulse, routed;
  logic               edit_cur;
  mode_t              mode_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (pcnt == PW'(CLK_DIV - 1));
      pcnt <= (pcnt == PW'(CLK_DIV - 1)) ? '0 : pcnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    clock_mode_ctrl_db #(.DB_TICKS(DB_TICKS)) u_db (
      .clk(clk), .rst(rst), .tick(tick), .raw(btn_raw[i]), .stable(stable[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stable_q <= '0;
    else     stable_q <= stable;
  end

  assign press = stable & ~stable_q;

`ifdef CLOCK_MODE_CTRL_AUTOREPEAT_EN
  localparam int REP_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int RW = $clog2(REP_MAX + 1);

  logic          rep_act, rep_first, rep_sel, rep_hold, rep_due;
  logic [RW-1:0] rep_cnt;

  // rep_sel: 1 tracks bD, 0 tracks bC; the latest press of either takes over.
  assign rep_hold = rep_sel ? stable[3] : stable[0];
  assign rep_due  = tick & rep_act & rep_hold & ~(press[3] | press[0]) &
                    (rep_first ? (rep_cnt == RW'(REP_DELAY - 1)) : (rep_cnt == RW'(REP_RATE - 1)));
  assign rep_pulse = rep_due ? (rep_sel ? 4'b1000 : 4'b0001) : 4'b0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_act   <= 1'b0;
      rep_first <= 1'b0;
      rep_sel   <= 1'b0;
      rep_cnt   <= '0;
    end else if (press[3] | press[0]) begin
      rep_act   <= 1'b1;
      rep_first <= 1'b1;
      rep_sel   <= press[3];
      rep_cnt   <= '0;
    end else if (rep_act) begin
      if (!rep_hold) begin
        rep_act <= 1'b0;
      end else if (tick) begin
        if (rep_due) begin
          rep_cnt   <= '0;
          rep_first <= 1'b0;
        end else begin
          rep_cnt <= rep_cnt + 1'b1;
        end
      end
    end
  end
`else
  assign rep_pulse = 4'b0000;
`endif

  // A bU press swallows repeats in the same cycle even when the mode is edit-locked.
  assign routed = press[3:0] | (press[4] ? 4'b0000 : rep_pulse);

  always_comb begin
    edit_cur = edit_in[0];
    case (mode_q)
      M_TMR:   edit_cur = edit_in[1];
      M_SW:    edit_cur = edit_in[2];
      default: edit_cur = edit_in[0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= M_CLK;
      btn_clk <= '0;
      btn_tmr <= '0;
      btn_sw  <= '0;
    end else begin
      btn_clk <= '0;
      btn_tmr <= '0;
      btn_sw  <= '0;
      if (press[4] && !edit_cur) begin
        case (mode_q)
          M_CLK:   mode_q <= M_TMR;
          M_TMR:   mode_q <= M_SW;
          default: mode_q <= M_CLK;
        endcase
      end else begin
        case (mode_q)
          M_TMR:   btn_tmr <= routed;
          M_SW:    btn_sw  <= routed;
          default: btn_clk <= routed;
        endcase
      end
    end
  end

  assign mode = mode_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_time <= '0;
      disp_edit <= 1'b0;
    end else begin
      case (mode_q)
        M_TMR:   begin disp_time <= time_tmr; disp_edit <= edit_in[1]; end
        M_SW:    begin disp_time <= time_sw;  disp_edit <= edit_in[2]; end
        default: begin disp_time <= time_clk; disp_edit <= edit_in[0]; end
      endcase
    end
  end
endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl: directed scenarios plus random button traffic against a cycle model.
module tb_clock_mode_ctrl;
  localparam int CLK_DIV = 4, DB = 3, RD = 5, RR = 2;

  logic        clk = 1'b0, rst = 1'b1;
  logic [4:0]  btn_raw = '0;
  logic [2:0]  edit_in = '0;
  logic [35:0] time_clk = 36'h100000001, time_tmr = 36'h200000002, time_sw = 36'h300000003;
  logic        tick, disp_edit;
  logic [1:0]  mode;
  logic [3:0]  btn_clk, btn_tmr, btn_sw;
  logic [35:0] disp_time;

  int tests = 0, fails = 0;

  clock_mode_ctrl #(.CLK_DIV(CLK_DIV), .DB_TICKS(DB), .REP_DELAY(RD), .REP_RATE(RR)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .edit_in(edit_in),
    .time_clk(time_clk), .time_tmr(time_tmr), .time_sw(time_sw),
    .tick(tick), .mode(mode), .btn_clk(btn_clk), .btn_tmr(btn_tmr), .btn_sw(btn_sw),
    .disp_time(disp_time), .disp_edit(disp_edit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails < 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: levels, run lengths in ticks, hold time in ticks since press.
  logic        m_tick;
  int          m_pc, m_mode, m_run[5], m_rwhich, m_rhold;
  logic [4:0]  m_r1, m_r2, m_stb, m_stbq;
  logic [3:0]  m_bus[3];
  logic [35:0] m_dt;
  logic        m_de;
  bit          m_ract;

  task automatic mreset();
    m_tick = 0; m_pc = 0; m_mode = 0; m_rwhich = 0; m_rhold = 0; m_ract = 0;
    m_r1 = 0; m_r2 = 0; m_stb = 0; m_stbq = 0; m_dt = 0; m_de = 0;
    for (int i = 0; i < 5; i++) m_run[i] = 0;
    for (int i = 0; i < 3; i++) m_bus[i] = 0;
  endtask

  task automatic mstep();
    logic [4:0]  pr, nstb;
    logic [3:0]  rep, route;
    logic [35:0] words[3];
    int          nrun[5];
    words = '{time_clk, time_tmr, time_sw};
    pr = m_stb & ~m_stbq;
    nstb = m_stb;
    for (int i = 0; i < 5; i++) begin
      nrun[i] = m_run[i];
      if (m_r2[i] == m_stb[i]) nrun[i] = 0;
      else if (m_tick) begin
        nrun[i] = m_run[i] + 1;
        if (nrun[i] == DB) begin nstb[i] = m_r2[i]; nrun[i] = 0; end
      end
    end
    rep = 0;
    if (pr[3] || pr[0]) begin
      m_ract = 1; m_rwhich = pr[3] ? 3 : 0; m_rhold = 0;
    end else if (m_ract) begin
      if (!m_stb[m_rwhich]) m_ract = 0;
      else if (m_tick) begin
        m_rhold++;
        if (m_rhold == RD || (m_rhold > RD && (m_rhold - RD) % RR == 0)) rep[m_rwhich] = 1'b1;
      end
    end
`ifndef CLOCK_MODE_CTRL_AUTOREPEAT_EN
    rep = 0;
`endif
    if (pr[4]) rep = 0;
    route = pr[3:0] | rep;
    for (int i = 0; i < 3; i++) m_bus[i] = 0;
    m_dt = words[m_mode];
    m_de = edit_in[m_mode];
    if (pr[4] && !edit_in[m_mode]) m_mode = (m_mode + 1) % 3;
    else m_bus[m_mode] = route;
    m_tick = (m_pc == CLK_DIV - 1);
    m_pc = (m_pc + 1) % CLK_DIV;
    m_stbq = m_stb; m_stb = nstb; m_r2 = m_r1; m_r1 = btn_raw;
    m_run = nrun;
  endtask

  initial begin
    mreset();
    forever begin
      @(posedge clk);
      if (rst) mreset(); else mstep();
      #1;
      chk("m_tick", 64'(tick), 64'(m_tick));
      chk("m_mode", 64'(mode), 64'(m_mode));
      chk("m_btn_clk", 64'(btn_clk), 64'(m_bus[0]));
      chk("m_btn_tmr", 64'(btn_tmr), 64'(m_bus[1]));
      chk("m_btn_sw", 64'(btn_sw), 64'(m_bus[2]));
      chk("m_disp_time", 64'(disp_time), 64'(m_dt));
      chk("m_disp_edit", 64'(disp_edit), 64'(m_de));
    end
  end

  task automatic tk();
    @(posedge clk); #2;
  endtask

  task automatic do_press(input int idx, input int hold, input int idle);
    btn_raw[idx] = 1'b1;
    repeat (hold) tk();
    btn_raw[idx] = 1'b0;
    repeat (idle) tk();
  endtask

  initial begin
    logic [1:0]  prev, expm[3];
    logic [35:0] expd[3];
    logic [3:0]  any, bt;
    int          n, first, seen;
    int          pulses[$];

    repeat (3) tk();
    chk("rst_tick", 64'(tick), 64'd0);
    chk("rst_mode", 64'(mode), 64'd0);
    chk("rst_btn", 64'({btn_clk, btn_tmr, btn_sw}), 64'd0);
    chk("rst_disp", 64'({disp_edit, disp_time}), 64'd0);
    rst = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tk();
      chk("tick_period", 64'(tick), 64'(c % 4 == 0));
    end

    // Glitch of 6 cycles spans at most two ticks
    do_press(0, 6, 0);
    n = 0;
    for (int c = 0; c < 30; c++) begin tk(); if (btn_clk !== 4'b0000) n++; end
    chk("glitch_no_pulse", 64'(n), 64'd0);

    btn_raw[0] = 1'b1; n = 0; first = -1;
    for (int c = 1; c <= 40; c++) begin
      tk();
      if (btn_clk === 4'b0001) begin n++; if (first < 0) first = c; end
    end
    chk("bc_one_pulse", 64'(n), 64'd1);
    chk("bc_latency_ok", 64'(first >= 11 && first <= 17), 64'd1);
    btn_raw[0] = 1'b0; n = 0;
    for (int c = 0; c < 30; c++) begin tk(); if ({btn_clk, btn_tmr, btn_sw} !== 12'd0) n++; end
    chk("release_no_pulse", 64'(n), 64'd0);

    expm = '{2'd1, 2'd2, 2'd0};
    expd = '{36'h200000002, 36'h300000003, 36'h100000001};
    for (int k = 0; k < 3; k++) begin
      prev = mode; seen = 0; any = 0;
      btn_raw[4] = 1'b1;
      for (int c = 0; c < 40; c++) begin
        tk();
        if (c >= 20) btn_raw[4] = 1'b0;
        any |= btn_clk | btn_tmr | btn_sw;
        if (seen == 0 && mode !== prev) begin
          seen = 1;
          chk("mode_cycle", 64'(mode), 64'(expm[k]));
          tk(); c++;
          chk("disp_follow", 64'(disp_time), 64'(expd[k]));
          any |= btn_clk | btn_tmr | btn_sw;
        end
      end
      btn_raw[4] = 1'b0;
      chk("mode_changed", 64'(seen), 64'd1);
      chk("mode_btn_quiet", 64'(any), 64'd0);
    end

    do_press(4, 20, 20);
    chk("mode_to_tmr", 64'(mode), 64'd1);
    edit_in = 3'b010;
    do_press(4, 20, 20);
    chk("edit_lock", 64'(mode), 64'd1);
    btn_raw[1] = 1'b1; bt = 0; any = 0;
    for (int c = 0; c < 40; c++) begin
      tk();
      if (c >= 20) btn_raw[1] = 1'b0;
      if (btn_tmr !== 4'b0000) bt = btn_tmr;
      any |= btn_clk | btn_sw;
    end
    btn_raw[1] = 1'b0;
    chk("edit_br_tmr", 64'(bt), 64'b0010);
    chk("edit_br_other", 64'(any), 64'd0);
    repeat (20) tk();

    edit_in = 3'b000; any = 0;
    btn_raw[4] = 1'b1; btn_raw[3] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tk();
      if (c >= 14) begin btn_raw[4] = 1'b0; btn_raw[3] = 1'b0; end
      any |= btn_clk | btn_tmr | btn_sw;
    end
    chk("simul_mode", 64'(mode), 64'd2);
    chk("simul_no_bd", 64'(any[3]), 64'd0);
    repeat (20) tk();

    btn_raw[0] = 1'b1;
    repeat (13) tk();
    rst = 1'b1;
    #1;
    chk("async_rst_outs", 64'({tick, mode, btn_clk, btn_tmr, btn_sw, disp_edit}), 64'd0);
    chk("async_rst_disp", 64'(disp_time), 64'd0);
    repeat (3) tk();
    rst = 1'b0; n = 0;
    for (int c = 0; c < 30; c++) begin tk(); if (btn_clk === 4'b0001) n++; end
    chk("held_thru_rst", 64'(n), 64'd1);
    btn_raw[0] = 1'b0;
    repeat (30) tk();

    // bD held for 48 cycles = 12 ticks of stable high, mode 0
    btn_raw[3] = 1'b1;
    for (int c = 0; c < 90; c++) begin
      tk();
      if (c >= 47) btn_raw[3] = 1'b0;
      if (btn_clk === 4'b1000) pulses.push_back(c);
    end
`ifdef CLOCK_MODE_CTRL_AUTOREPEAT_EN
    chk("rep_count", 64'(pulses.size()), 64'd5);
    if (pulses.size() == 5) begin
      chk("rep_gap1", 64'(pulses[1] - pulses[0]), 64'd19);
      chk("rep_gap2", 64'(pulses[2] - pulses[1]), 64'd8);
      chk("rep_gap3", 64'(pulses[4] - pulses[3]), 64'd8);
    end
`else
    chk("single_pulse", 64'(pulses.size()), 64'd1);
`endif

    for (int it = 0; it < 200; it++) begin
      btn_raw = 5'($urandom);
      edit_in = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        time_clk = {4'($urandom), 32'($urandom)};
        time_tmr = {4'($urandom), 32'($urandom)};
        time_sw  = {4'($urandom), 32'($urandom)};
      end
      if ($urandom_range(0, 49) == 0) begin rst = 1'b1; tk(); tk(); rst = 1'b0; end
      repeat ($urandom_range(1, 40)) tk();
    end
    btn_raw = '0;
    repeat (40) tk();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
